// File: rtl/serial_recv.sv
// serial_recv: UART receiver, 8N1 (8E1 when SERIAL_RECV_PARITY_EN is defined).
// Two-flop synchronizer on DATA_IN, mid-bit sampling, one-cycle VALID strobe
// with DATA_OUT/FERR/PERR held until the next completed frame.
module serial_recv #(
  parameter int WAIT_DIV = 10
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       DATA_IN,
  output logic [7:0] DATA_OUT,
  output logic       VALID,
  output logic       FERR,
  output logic       PERR,
  output logic       BUSY
);
  localparam int HALF     = WAIT_DIV / 2;
  localparam int WAIT_LEN = $clog2(WAIT_DIV);
  localparam logic [WAIT_LEN-1:0] CNT_LAST = WAIT_LEN'(WAIT_DIV - 1);
  localparam logic [WAIT_LEN-1:0] CNT_HALF = WAIT_LEN'(HALF - 1);

`ifdef SERIAL_RECV_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, WAIT_HIGH} state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HIGH} state_t;
`endif

  state_t              state_q, state_d;
  logic                rx_meta_q, rx_s_q;
  logic [WAIT_LEN-1:0] wait_cnt_q, wait_cnt_d;
  logic [2:0]          bit_cnt_q, bit_cnt_d;
  logic [7:0]          shift_q, shift_d;
  logic [7:0]          data_q, data_d;
  logic                valid_q, valid_d;
  logic                ferr_q, ferr_d;
`ifdef SERIAL_RECV_PARITY_EN
  logic                parity_q, parity_d;
  logic                perr_q, perr_d;
`endif

  // State, counters, synchronizer and output registers
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= IDLE;
      rx_meta_q  <= 1'b1;
      rx_s_q     <= 1'b1;
      wait_cnt_q <= '0;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      ferr_q     <= 1'b0;
`ifdef SERIAL_RECV_PARITY_EN
      parity_q   <= 1'b0;
      perr_q     <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      rx_meta_q  <= DATA_IN;
      rx_s_q     <= rx_meta_q;
      wait_cnt_q <= wait_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      ferr_q     <= ferr_d;
`ifdef SERIAL_RECV_PARITY_EN
      parity_q   <= parity_d;
      perr_q     <= perr_d;
`endif
    end
  end

  // Next-state and datapath: everything holds unless a sample point is reached
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    data_d     = data_q;
    valid_d    = 1'b0;
    ferr_d     = ferr_q;
`ifdef SERIAL_RECV_PARITY_EN
    parity_d   = parity_q;
    perr_d     = perr_q;
`endif
    case (state_q)
      IDLE: begin
        if (!rx_s_q) begin
          state_d    = START;
          wait_cnt_d = '0;
        end
      end
      START: begin
        if (wait_cnt_q == CNT_HALF) begin
          wait_cnt_d = '0;
          bit_cnt_d  = '0;
          // A start bit that has gone high again by mid-bit is a glitch
          state_d    = rx_s_q ? IDLE : DATA;
        end else begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
      end
      DATA: begin
        if (wait_cnt_q == CNT_LAST) begin
          shift_d    = {rx_s_q, shift_q[7:1]};
          wait_cnt_d = '0;
          if (bit_cnt_q == 3'd7) begin
`ifdef SERIAL_RECV_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end else begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
      end
`ifdef SERIAL_RECV_PARITY_EN
      PARITY: begin
        if (wait_cnt_q == CNT_LAST) begin
          parity_d   = rx_s_q;
          wait_cnt_d = '0;
          state_d    = STOP;
        end else begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
      end
`endif
      STOP: begin
        if (wait_cnt_q == CNT_LAST) begin
          valid_d    = 1'b1;
          data_d     = shift_q;
          ferr_d     = ~rx_s_q;
`ifdef SERIAL_RECV_PARITY_EN
          perr_d     = ^{shift_q, parity_q};
`endif
          wait_cnt_d = '0;
          // Leave at mid stop bit so a back-to-back start edge is not missed
          state_d    = rx_s_q ? IDLE : WAIT_HIGH;
        end else begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
      end
      WAIT_HIGH: begin
        if (rx_s_q) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign DATA_OUT = data_q;
  assign VALID    = valid_q;
  assign FERR     = ferr_q;
  assign BUSY     = (state_q != IDLE);
`ifdef SERIAL_RECV_PARITY_EN
  assign PERR     = perr_q;
`else
  assign PERR     = 1'b0;
`endif

endmodule
